// File: rtl/lcd_cmd_sched.sv
// lcd_cmd_sched: queues host opcodes for the 8x8 LCD image engine, issues one
// per engine busy-low window, seals on WRITE and reports issue/err/timeout status.
// Ports: clk; reset (async, active-low); host_cmd/host_valid/host_ready (host push);
//   busy/done (engine status); cmd/cmd_valid (issue strobe to engine);
//   issued_cnt, err, timeout, seq_done (sequence status).
module lcd_cmd_sched #(
  parameter int DEPTH   = 8,
  parameter int PTR_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] host_cmd,
  input  logic       host_valid,
  output logic       host_ready,
  input  logic       busy,
  input  logic       done,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic [7:0] issued_cnt,
  output logic       err,
  output logic       timeout,
  output logic       seq_done
);

  typedef enum logic [2:0] {
    S_WAIT_LO,
    S_ISSUE,
    S_WAIT_HI,
    S_DRAIN,
    S_FIN
  } state_e;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [7:0]     WD_LAST  = 8'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic [3:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic       sealed_q, sealed_d;
  logic       alive_q;
  logic       err_q, err_d;
  logic       to_q, to_d;
  logic [7:0] wd_q, wd_d;
  logic [7:0] issued_q, issued_d;
  logic [3:0] cmd_q, cmd_d;
  logic       cv_q, cv_d;

  logic       full;
  logic       empty;
  logic       push;
  logic       legal;
  logic       wr;
  logic       pop;
  logic       wd_tick;
  logic       wd_trip;
  logic [3:0] head;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // alive_q keeps host_ready low while reset is held
  assign host_ready = alive_q && !full && !sealed_q
                   && (state_q != S_FIN);

  assign push  = host_valid && host_ready;
  assign legal = (host_cmd < 4'd12);
  assign wr    = push && legal;

  // FIFO bookkeeping
  always_comb begin
    wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case (1'b1)
      (wr && !pop): count_d = count_q + 1'b1;
      (!wr && pop): count_d = count_q - 1'b1;
      default:      count_d = count_q;
    endcase
    sealed_d = sealed_q || (wr && host_cmd == 4'd0);
    err_d    = err_q || (push && !legal);
  end

  // watchdog counts engine-stall cycles for the command in flight
  always_comb begin
    wd_tick = 1'b0;
    unique case (state_q)
      S_WAIT_LO, S_WAIT_HI: wd_tick = busy;
      S_DRAIN:              wd_tick = !done;
      default:              wd_tick = 1'b0;
    endcase
    wd_trip = wd_tick && (wd_q == WD_LAST);
  end

  always_comb begin
    state_d  = state_q;
    cv_d     = 1'b0;
    cmd_d    = cmd_q;
    pop      = 1'b0;
    issued_d = issued_q;
    to_d     = to_q;
    wd_d     = wd_tick ? wd_q + 8'd1 : wd_q;
    unique case (state_q)
      S_WAIT_LO: begin
        if (wd_trip) begin
          to_d    = 1'b1;
          state_d = S_FIN;
        end else if (!busy && !empty) begin
          cv_d    = 1'b1;
          cmd_d   = head;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        pop      = 1'b1;
        wd_d     = 8'd0;
        issued_d = (issued_q == 8'hFF) ? issued_q
                                       : issued_q + 8'd1;
        state_d  = (head == 4'd0) ? S_DRAIN : S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (wd_trip) begin
          to_d    = 1'b1;
          state_d = S_FIN;
        end else if (busy) begin
          state_d = S_WAIT_LO;
        end
      end
      S_DRAIN: begin
        if (done) begin
          state_d = S_FIN;
        end else if (wd_trip) begin
          to_d    = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_FIN;
        wd_d    = wd_q;
      end
      default: state_d = S_WAIT_LO;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_WAIT_LO;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sealed_q <= 1'b0;
      alive_q  <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      wd_q     <= 8'd0;
      issued_q <= 8'd0;
      cmd_q    <= 4'd0;
      cv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sealed_q <= sealed_d;
      alive_q  <= 1'b1;
      err_q    <= err_d;
      to_q     <= to_d;
      wd_q     <= wd_d;
      issued_q <= issued_d;
      cmd_q    <= cmd_d;
      cv_q     <= cv_d;
    end
  end

  // storage needs no reset: pointers and count define validity
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= host_cmd;
  end

  assign cmd        = cmd_q;
  assign cmd_valid  = cv_q;
  assign issued_cnt = issued_q;
  assign err        = err_q;
  assign timeout    = to_q;
  assign seq_done   = (state_q == S_FIN);

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// tb_lcd_cmd_sched: randomized and directed bench for lcd_cmd_sched
// against a queue-based reference model of the scheduler.
module tb_lcd_cmd_sched;
  localparam int DEPTH   = 8;
  localparam int PTR_W   = 3;
  localparam int TIMEOUT = 255;

  localparam int PH_LO  = 0;
  localparam int PH_ISS = 1;
  localparam int PH_HI  = 2;
  localparam int PH_DR  = 3;
  localparam int PH_FIN = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] host_cmd = 4'd0;
  logic       host_valid = 1'b0;
  logic       busy = 1'b0;
  logic       done = 1'b0;
  logic       host_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [7:0] issued_cnt;
  logic       err;
  logic       timeout;
  logic       seq_done;

  lcd_cmd_sched #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .host_cmd(host_cmd), .host_valid(host_valid),
    .host_ready(host_ready),
    .busy(busy), .done(done),
    .cmd(cmd), .cmd_valid(cmd_valid),
    .issued_cnt(issued_cnt), .err(err),
    .timeout(timeout), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int q_m[$];
  bit m_sealed, m_err, m_to, m_alive, m_cv;
  int m_ph, m_cnt, m_wd, m_cmd;

  function automatic bit m_ready();
    return m_alive && (q_m.size() < DEPTH)
        && !m_sealed && (m_ph != PH_FIN);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_m.delete();
      m_sealed = 0; m_err = 0; m_to = 0;
      m_alive = 0; m_cv = 0;
      m_ph = PH_LO; m_cnt = 0; m_wd = 0; m_cmd = 0;
    end else begin : upd
      bit pu;
      int hc;
      int h;
      pu = host_valid && m_ready();
      hc = int'(host_cmd);
      m_cv = 0;
      case (m_ph)
        PH_LO: begin
          if (busy) begin
            m_wd++;
            if (m_wd >= TIMEOUT) begin m_to = 1; m_ph = PH_FIN; end
          end else if (q_m.size() > 0) begin
            m_ph = PH_ISS; m_cv = 1; m_cmd = q_m[0];
          end
        end
        PH_ISS: begin
          h = q_m.pop_front();
          if (m_cnt < 255) m_cnt++;
          m_wd = 0;
          m_ph = (h == 0) ? PH_DR : PH_HI;
        end
        PH_HI: begin
          if (busy) begin
            m_wd++;
            if (m_wd >= TIMEOUT) begin m_to = 1; m_ph = PH_FIN; end
            else m_ph = PH_LO;
          end
        end
        PH_DR: begin
          if (done) m_ph = PH_FIN;
          else begin
            m_wd++;
            if (m_wd >= TIMEOUT) begin m_to = 1; m_ph = PH_FIN; end
          end
        end
        default: ;
      endcase
      if (pu) begin
        if (hc >= 12) m_err = 1;
        else begin
          q_m.push_back(hc);
          if (hc == 0) m_sealed = 1;
        end
      end
      m_alive = 1;
    end
  end

  // ---------------- compare + monitor ----------------
  int log_q[$];
  int ncyc = 0;
  int t_cv = -1, t_to = -1, t_done = -1, t_sd = -1;

  always @(negedge clk) begin
    ncyc++;
    chk("host_ready", host_ready, m_ready());
    chk("cmd_valid", cmd_valid, m_cv);
    chk("cmd", cmd, m_cmd);
    chk("issued_cnt", issued_cnt, m_cnt);
    chk("err", err, m_err);
    chk("timeout", timeout, m_to);
    chk("seq_done", seq_done, m_ph == PH_FIN);
    if (cmd_valid === 1'b1) log_q.push_back(int'(cmd));
    if (cmd_valid === 1'b1 && t_cv < 0) t_cv = ncyc;
    if (timeout === 1'b1 && t_to < 0) t_to = ncyc;
    if (done === 1'b1 && t_done < 0) t_done = ncyc;
    if (seq_done === 1'b1 && t_sd < 0) t_sd = ncyc;
  end

  // ---------------- engine model ----------------
  // mode 0: busy for a random span after each issue
  // mode 1: busy forced high, mode 2: busy forced low
  // mode 3: busy sticks high after the first issue
  int eng_mode = 0;
  int bmin = 2, bmax = 5;
  int done_dly = 70;
  bit spur = 0;
  int bcnt = 0, dcnt = 0;

  initial forever begin
    @(negedge clk); #1;
    if (!reset) begin
      bcnt = 0; dcnt = 0;
    end else if (cmd_valid) begin
      bcnt = (eng_mode == 3) ? 1000000 : $urandom_range(bmax, bmin);
      if (cmd == 4'd0) dcnt = done_dly;
    end
    case (eng_mode)
      1: busy = 1'b1;
      2: busy = 1'b0;
      default: busy = (bcnt > 0);
    endcase
    if (bcnt > 0) bcnt--;
    done = (dcnt == 1)
        || (spur && dcnt == 0 && $urandom_range(15, 0) == 0);
    if (dcnt > 0) dcnt--;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_reset();
    host_valid = 1'b0;
    reset = 1'b0;
    step(2);
    log_q.delete();
    t_cv = -1; t_to = -1; t_done = -1; t_sd = -1;
    reset = 1'b1;
    step(1);
  endtask

  task automatic push(input logic [3:0] c);
    int k = 0;
    host_cmd = c;
    host_valid = 1'b1;
    while (!host_ready && k < 50) begin step(1); k++; end
    chk("push_ready", host_ready, 1);
    step(1);
    host_valid = 1'b0;
  endtask

  task automatic offer(input logic [3:0] c, input int n);
    host_cmd = c;
    host_valid = 1'b1;
    step(n);
    host_valid = 1'b0;
  endtask

  task automatic wait_sd(input string nm, input int lim);
    int k = 0;
    while (!seq_done && k < lim) begin step(1); k++; end
    chk(nm, seq_done, 1);
  endtask

  task automatic chk_log(input string nm, input int e[$]);
    chk({nm, "_len"}, log_q.size(), e.size());
    foreach (e[i])
      if (i < log_q.size()) chk(nm, log_q[i], e[i]);
  endtask

  initial begin
    int k;
    int r;

    // reset state
    step(1);
    chk("rst_host_ready", host_ready, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_seq_done", seq_done, 0);
    reset = 1'b1;
    step(2);
    chk("ready_after_rst", host_ready, 1);

    // basic sequence
    do_reset();
    bmin = 2; bmax = 2; done_dly = 70;
    push(4'd1); push(4'd5); push(4'd9); push(4'd0);
    wait_sd("basic_seq_done", 400);
    chk_log("basic_order", '{1, 5, 9, 0});
    chk("basic_issued", issued_cnt, 4);
    chk("basic_err", err, 0);
    // done is driven just after a falling edge, so the first falling-edge
    // sample that shows done also shows the edge that consumed it
    chk("basic_sd_after_done", t_sd - t_done, 0);

    // illegal opcodes
    do_reset();
    bmin = 2; bmax = 5;
    push(4'd3);
    chk("illegal_err_before", err, 0);
    push(4'd13);
    chk("illegal_err_after", err, 1);
    push(4'd4); push(4'd0);
    wait_sd("illegal_seq_done", 400);
    chk_log("illegal_order", '{3, 4, 0});
    chk("illegal_issued", issued_cnt, 3);

    // full FIFO
    do_reset();
    eng_mode = 1;
    push(4'd7); push(4'd1); push(4'd11); push(4'd4);
    push(4'd9); push(4'd2); push(4'd10); push(4'd3);
    chk("full_ready_low", host_ready, 0);
    offer(4'd5, 3);
    eng_mode = 0;
    k = 0;
    while (log_q.size() < 8 && k < 300) begin step(1); k++; end
    step(10);
    chk_log("full_order", '{7, 1, 11, 4, 9, 2, 10, 3});
    chk("full_issued", issued_cnt, 8);

    // seal
    do_reset();
    push(4'd2); push(4'd0);
    chk("seal_ready_low", host_ready, 0);
    offer(4'd7, 4);
    wait_sd("seal_seq_done", 400);
    chk_log("seal_order", '{2, 0});

    // watchdog
    do_reset();
    eng_mode = 3;
    push(4'd6);
    wait_sd("wd_seq_done", 400);
    chk("wd_timeout", timeout, 1);
    chk("wd_latency", t_to - t_cv, TIMEOUT + 1);
    eng_mode = 0;

    // reset mid-run
    do_reset();
    eng_mode = 1;
    push(4'd3); push(4'd8); push(4'd5); push(4'd1);
    eng_mode = 2;
    k = 0;
    while (log_q.size() < 1 && k < 50) begin step(1); k++; end
    step(2);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", host_ready, 0);
    chk("mid_rst_cv", cmd_valid, 0);
    chk("mid_rst_cmd", cmd, 0);
    chk("mid_rst_issued", issued_cnt, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_to", timeout, 0);
    chk("mid_rst_sd", seq_done, 0);
    step(2);
    log_q.delete();
    eng_mode = 0;
    reset = 1'b1;
    step(2);
    chk("mid_rel_ready", host_ready, 1);
    step(10);
    chk("mid_no_stale", log_q.size(), 0);

    // randomized traffic
    for (int rnd = 0; rnd < 6; rnd++) begin
      do_reset();
      spur = 1'b1;
      bmin = 2; bmax = 6;
      done_dly = (rnd == 5) ? 0 : $urandom_range(40, 5);
      for (int c = 0; c < 150; c++) begin
        r = $urandom_range(99, 0);
        host_valid = ($urandom_range(2, 0) != 0);
        if (r < 4) host_cmd = 4'd0;
        else if (r < 12) host_cmd = 4'($urandom_range(15, 12));
        else host_cmd = 4'($urandom_range(11, 1));
        step(1);
      end
      host_valid = 1'b0;
      step(40);
      spur = 1'b0;
    end

    // saturation-free long run: many legal pushes, no WRITE
    do_reset();
    bmin = 2; bmax = 3;
    for (int c = 0; c < 20; c++) push(4'($urandom_range(11, 1)));
    step(60);
    chk("long_issued", issued_cnt, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
